cond_inst_queue: RTL and testbench

//  Parametrised instruction prefetch queue with ARM condition-code evaluation at issue.

---
 rtl/arm_cond_pkg.sv | 53 +++++
 rtl/cond_eval.sv | 12 +
 rtl/cond_inst_queue.sv | 99 +++++++++
 tb/tb_cond_inst_queue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_cond_pkg.sv
// ARM condition-code constants and the shared pass/fail function used by the
// instruction queue and any future conditional-execute units.
package arm_cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[N_BIT];
    z = nzcv[Z_BIT];
    c = nzcv[C_BIT];
    v = nzcv[V_BIT];
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c & !z;
      COND_LS: cond_pass = !c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator: 4-bit cond field + NZCV -> pass.
module cond_eval
  import arm_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  assign pass = cond_pass(cond, nzcv);

endmodule

// File: rtl/cond_inst_queue.sv
// Instruction prefetch queue that evaluates the head's ARM condition at issue.
// Optional macro COND_INSTQ_SKIP_CNT_EN enables the saturating skipped-word counter.
module cond_inst_queue
  import arm_cond_pkg::*;
#(
  parameter int INST_W   = 32,
  parameter int DEPTH    = 4,
  parameter int COND_MSB = 31,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     Rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INST_W-1:0]        in_inst,
  input  logic [3:0]               NZCV,
  input  logic                     Write_IR,
  input  logic                     flush,
  output logic                     flag,
  output logic                     ir_valid,
  output logic [INST_W-1:0]        IR_complete,
  output logic                     skipped,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         skip_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [INST_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count_q;
  logic [INST_W-1:0] head;
  logic              head_pass, empty, full, push, pop;

  assign head  = mem[rd_ptr];
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  cond_eval u_cond_eval (
    .cond (head[COND_MSB -: 4]),
    .nzcv (NZCV),
    .pass (head_pass)
  );

  assign flag     = !empty & head_pass;
  assign pop      = Write_IR & !empty & !flush;
  // A full queue still accepts when the head leaves in the same cycle.
  assign in_ready = !full | pop;
  assign push     = in_valid & in_ready & !flush;
  assign count    = count_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_inst;
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
      ir_valid    <= 1'b0;
      skipped     <= 1'b0;
      IR_complete <= '0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      ir_valid <= 1'b0;
      skipped  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      ir_valid <= pop & flag;
      skipped  <= pop & !flag;
      if (pop & flag) IR_complete <= head;
    end
  end

`ifdef COND_INSTQ_SKIP_CNT_EN
  logic [CNT_W-1:0] skip_q;

  // Saturates at all-ones; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n)                     skip_q <= '0;
    else if (skipped && !(&skip_q)) skip_q <= skip_q + 1'b1;
  end

  assign skip_cnt = skip_q;
`else
  assign skip_cnt = '0;
`endif

endmodule

// File: tb/tb_cond_inst_queue.sv
// Self-checking bench for cond_inst_queue with a scoreboard of expected issue results.
module tb_cond_inst_queue;

  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [INST_W-1:0] in_inst = '0;
  logic [3:0]        NZCV = '0;
  logic              Write_IR = 1'b0;
  logic              flush = 1'b0;
  logic              flag, ir_valid, skipped;
  logic [INST_W-1:0] IR_complete;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0]  skip_cnt;

  typedef struct packed {
    logic              issued;
    logic [INST_W-1:0] inst;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passed = 0;
  logic [31:0] exp_ir = '0;
  int          exp_skip = 0;

  cond_inst_queue #(.INST_W(INST_W), .DEPTH(DEPTH), .COND_MSB(31), .CNT_W(CNT_W)) dut (
    .clk(clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .NZCV(NZCV), .Write_IR(Write_IR), .flush(flush), .flag(flag), .ir_valid(ir_valid),
    .IR_complete(IR_complete), .skipped(skipped), .count(count), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Table grouped as base condition (cond[3:1]) with cond[0] inverting it.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy & ~z;
      3'd5: b = ~(n ^ v);
      3'd6: b = ~z & ~(n ^ v);
      default: b = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? ~b : b;
  endfunction

  function automatic logic [CNT_W-1:0] exp_skip_cnt();
`ifdef COND_INSTQ_SKIP_CNT_EN
    return CNT_W'(exp_skip);
`else
    return '0;
`endif
  endfunction

  task automatic test_reset();
    in_valid = 1'b1; in_inst = 32'hE0C0FFEE; tick();
    in_valid = 1'b1; in_inst = 32'hE0000002; Write_IR = 1'b1; tick();
    in_valid = 1'b1; in_inst = 32'hE0000003; Write_IR = 1'b0; tick();
    in_valid = 1'b0;
    checks++; if (IR_complete !== 32'hE0C0FFEE) $display("FAIL reset_pre_ir: got %h want %h", IR_complete, 32'hE0C0FFEE); else passed++;
    checks++; if (count !== 3'd2) $display("FAIL reset_pre_count: got %0d want 2", count); else passed++;
    #2 Rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
    checks++; if (IR_complete !== 32'h0) $display("FAIL reset_ir: got %h want 0", IR_complete); else passed++;
    checks++; if (ir_valid !== 1'b0 || skipped !== 1'b0) $display("FAIL reset_pulses: got ir_valid=%b skipped=%b want 0 0", ir_valid, skipped); else passed++;
    checks++; if (flag !== 1'b0) $display("FAIL reset_flag: got %b want 0", flag); else passed++;
    checks++; if (skip_cnt !== '0) $display("FAIL reset_skip_cnt: got %0d want 0", skip_cnt); else passed++;
    tick();
    Rst_n = 1'b1;
    exp_ir = '0; exp_skip = 0; sb.delete();
    tick();
  endtask

  task automatic test_cond_table();
    exp_t e;
    logic p;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        in_valid = 1'b1; in_inst = {4'(c), 4'h0, 4'(f), 20'h5A5A5}; Write_IR = 1'b0; NZCV = 4'h0;
        tick();
        in_valid = 1'b0; NZCV = 4'(f); Write_IR = 1'b1;
        p = ref_pass(4'(c), 4'(f));
        sb.push_back('{issued: p, inst: in_inst});
        #1;
        checks++; if (flag !== p) $display("FAIL cond_flag c=%h nzcv=%b: got %b want %b", c, f, flag, p); else passed++;
        tick();
        Write_IR = 1'b0;
        e = sb.pop_front();
        checks++;
        if (ir_valid !== e.issued || skipped !== !e.issued)
          $display("FAIL cond_pulse c=%h nzcv=%b: got ir_valid=%b skipped=%b want %b %b", c, f, ir_valid, skipped, e.issued, !e.issued);
        else passed++;
        if (e.issued) exp_ir = e.inst; else exp_skip++;
        checks++; if (IR_complete !== exp_ir) $display("FAIL cond_ir c=%h nzcv=%b: got %h want %h", c, f, IR_complete, exp_ir); else passed++;
      end
    end
    tick();
    checks++; if (skip_cnt !== exp_skip_cnt()) $display("FAIL cond_skip_cnt: got %0d want %0d", skip_cnt, exp_skip_cnt()); else passed++;
    checks++; if (count !== 3'd0) $display("FAIL cond_count: got %0d want 0", count); else passed++;
  endtask

  task automatic test_full();
    exp_t e;
    NZCV = 4'h0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_inst = 32'hE0000100 + 32'(i); Write_IR = 1'b0;
      sb.push_back('{issued: 1'b1, inst: in_inst});
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd4) $display("FAIL full_count: got %0d want 4", count); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", in_ready); else passed++;
    in_valid = 1'b1; in_inst = 32'hE0000104; Write_IR = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL full_ready_pop: got %b want 1", in_ready); else passed++;
    sb.push_back('{issued: 1'b1, inst: in_inst});
    tick();
    checks++; if (count !== 3'd4) $display("FAIL full_count_pushpop: got %0d want 4", count); else passed++;
    in_valid = 1'b0;
    for (int i = 0; i < 6 && sb.size() > 0; i++) begin
      if (ir_valid) begin
        e = sb.pop_front();
        exp_ir = e.inst;
        checks++; if (IR_complete !== e.inst) $display("FAIL full_order: got %h want %h", IR_complete, e.inst); else passed++;
      end
      if (sb.size() > 0) tick();
    end
    Write_IR = 1'b0;
    checks++; if (sb.size() != 0) $display("FAIL full_drain: got %0d words left want 0", sb.size()); else passed++;
    tick();
    checks++; if (count !== 3'd0) $display("FAIL full_count_end: got %0d want 0", count); else passed++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_inst = 32'hE0000200 + 32'(i); tick();
    end
    in_valid = 1'b1; in_inst = 32'hE0000999; Write_IR = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; Write_IR = 1'b0;
    checks++; if (count !== 3'd0) $display("FAIL flush_count: got %0d want 0", count); else passed++;
    checks++; if (IR_complete !== exp_ir) $display("FAIL flush_ir: got %h want %h", IR_complete, exp_ir); else passed++;
    checks++; if (ir_valid !== 1'b0 || skipped !== 1'b0) $display("FAIL flush_pulses: got %b %b want 0 0", ir_valid, skipped); else passed++;
    checks++; if (flag !== 1'b0) $display("FAIL flush_flag: got %b want 0", flag); else passed++;
    in_valid = 1'b1; in_inst = 32'hE0000AAA; tick();
    in_valid = 1'b0; Write_IR = 1'b1; tick();
    Write_IR = 1'b0;
    checks++; if (ir_valid !== 1'b1 || IR_complete !== 32'hE0000AAA) $display("FAIL flush_after: got v=%b ir=%h want 1 %h", ir_valid, IR_complete, 32'hE0000AAA); else passed++;
    exp_ir = 32'hE0000AAA;
  endtask

  task automatic test_skip();
    in_valid = 1'b1; in_inst = 32'hF1234567; NZCV = 4'hF; tick();
    in_valid = 1'b0; Write_IR = 1'b1;
    #1;
    checks++; if (flag !== 1'b0) $display("FAIL skip_flag: got %b want 0", flag); else passed++;
    tick();
    Write_IR = 1'b0;
    exp_skip++;
    checks++; if (skipped !== 1'b1 || ir_valid !== 1'b0) $display("FAIL skip_pulse: got skipped=%b ir_valid=%b want 1 0", skipped, ir_valid); else passed++;
    checks++; if (IR_complete !== exp_ir) $display("FAIL skip_ir: got %h want %h", IR_complete, exp_ir); else passed++;
    tick();
    checks++; if (skipped !== 1'b0) $display("FAIL skip_pulse_end: got %b want 0", skipped); else passed++;
    checks++; if (skip_cnt !== exp_skip_cnt()) $display("FAIL skip_cnt: got %0d want %0d", skip_cnt, exp_skip_cnt()); else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int sent = 0;
    int issued = 0;
    NZCV = 4'h0;
    for (int c = 0; c < 20 && issued < 10; c++) begin
      in_valid = (sent < 10); in_inst = 32'hE00B0000 + 32'(sent); Write_IR = 1'b1;
      #1;
      if (in_valid) begin
        checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready cyc %0d: got %b want 1", c, in_ready); else passed++;
        sb.push_back('{issued: 1'b1, inst: in_inst});
        sent++;
      end
      tick();
      if (c == 0) begin
        checks++; if (ir_valid !== 1'b0) $display("FAIL b2b_first: got ir_valid=%b want 0", ir_valid); else passed++;
      end
      if (ir_valid) begin
        if (sb.size() == 0) begin
          checks++; $display("FAIL b2b_extra: got unexpected issue %h want none", IR_complete);
        end else begin
          e = sb.pop_front();
          exp_ir = e.inst;
          checks++; if (IR_complete !== e.inst) $display("FAIL b2b_order: got %h want %h", IR_complete, e.inst); else passed++;
        end
        issued++;
      end
    end
    in_valid = 1'b0; Write_IR = 1'b0;
    checks++; if (issued != 10) $display("FAIL b2b_issued: got %0d want 10", issued); else passed++;
    tick();
    checks++; if (count !== 3'd0) $display("FAIL b2b_count: got %0d want 0", count); else passed++;
  endtask

  initial begin
    tick(); tick();
    Rst_n = 1'b1;
    tick();
    test_reset();
    test_cond_table();
    test_full();
    test_flush();
    test_skip();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
